pep_ks_boram_wr_ctrl: RTL and testbench

PEP_KS_BORAM_WR_CTRL -- requirements
Module: pep_ks_boram_wr_ctrl

---
 rtl/pep_ks_common_param_pkg.sv | 20 ++
 rtl/pep_ks_err_acc.sv | 54 +++++
 rtl/pep_ks_boram_wr_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pep_ks_boram_wr_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pep_ks_common_param_pkg.sv
// Shared widths, error-path FSM states and parameter legality helpers for the
// keyswitch body-RAM write controller.
package pep_ks_common_param_pkg;

  localparam int KS_MAX_ERROR_W = 8;
  localparam int MOD_KSK_W      = 32;
  localparam int PID_W          = 4;

  typedef enum logic [1:0] {
    ERR_ST_IDLE = 2'd0,
    ERR_ST_ACC  = 2'd1,
    ERR_ST_EMIT = 2'd2
  } err_state_e;

  // An error sample must fit in the accumulator without truncation.
  function automatic bit err_in_w_legal(input int err_in_w);
    return (err_in_w > 0) && (err_in_w <= KS_MAX_ERROR_W);
  endfunction

endpackage

// File: rtl/pep_ks_err_acc.sv
// Signed error accumulator: load or add a sign-extended sample each cycle.
// Saturates when PEP_KS_BORAM_SAT_EN is defined, otherwise wraps (two's complement).
module pep_ks_err_acc
  import pep_ks_common_param_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int ACC_W = KS_MAX_ERROR_W
) (
  input  logic                    clk,
  input  logic                    s_rst,
  input  logic                    i_load,
  input  logic                    i_add,
  input  logic signed [IN_W-1:0]  i_sample,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] w_next;

  assign w_ext = ACC_W'(i_sample);

`ifdef PEP_KS_BORAM_SAT_EN
  logic signed [ACC_W:0] w_sum_wide;

  // One guard bit is enough: the sample is never wider than the accumulator.
  assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext};

  always_comb begin
    w_next = w_sum_wide[ACC_W-1:0];
    if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
      w_next = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign w_next = r_acc + w_ext;
`endif

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_ext;
    end else if (i_add) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/pep_ks_boram_wr_ctrl.sv
// Body-RAM write controller: registers body writes and folds per-pid error columns
// into one correction write. Define PEP_KS_BORAM_SAT_EN for saturating accumulation.
module pep_ks_boram_wr_ctrl
  import pep_ks_common_param_pkg::*;
#(
  parameter int ERR_IN_W = 8,
  parameter int OUT_PIPE = 1
) (
  input  logic                       clk,
  input  logic                       s_rst,

  input  logic                       ms_err_vld,
  output logic                       ms_err_rdy,
  input  logic signed [ERR_IN_W-1:0] ms_err_data,
  input  logic [PID_W-1:0]           ms_err_pid,
  input  logic                       ms_err_last,

  input  logic                       body_vld,
  output logic                       body_rdy,
  input  logic [MOD_KSK_W-1:0]       body_data,
  input  logic [PID_W-1:0]           body_pid,
  input  logic                       body_parity,

  output logic                       ks_boram_wr_en,
  output logic [MOD_KSK_W-1:0]       ks_boram_wr_data,
  output logic [PID_W-1:0]           ks_boram_wr_pid,
  output logic                       ks_boram_wr_parity,

  output logic                       ks_boram_corr_wr_en,
  output logic [KS_MAX_ERROR_W-1:0]  ks_boram_corr_wr_data,
  output logic [PID_W-1:0]           ks_boram_corr_wr_pid,

  output logic                       err_pid_mismatch
);

  if (!err_in_w_legal(ERR_IN_W)) begin : g_err_in_w_chk
    $error("ERR_IN_W=%0d must be in 1..KS_MAX_ERROR_W=%0d", ERR_IN_W, KS_MAX_ERROR_W);
  end
  if ((OUT_PIPE != 0) && (OUT_PIPE != 1)) begin : g_out_pipe_chk
    $error("OUT_PIPE=%0d must be 0 or 1", OUT_PIPE);
  end

  // ---------------------------------------------------------------- body path
  logic                 r_body_en;
  logic [MOD_KSK_W-1:0] r_body_data;
  logic [PID_W-1:0]     r_body_pid;
  logic                 r_body_parity;

  assign body_rdy = ~s_rst;

  always_ff @(posedge clk) begin
    if (s_rst) r_body_en <= 1'b0;
    else       r_body_en <= body_vld;
  end

  // NOTE: payload registers carry no reset; they are only meaningful while the
  // matching enable is high, and leaving them unreset keeps them plain flops.
  always_ff @(posedge clk) begin
    if (body_vld) begin
      r_body_data   <= body_data;
      r_body_pid    <= body_pid;
      r_body_parity <= body_parity;
    end
  end

  // --------------------------------------------------------------- error path
  err_state_e                 r_state;
  err_state_e                 w_next_state;
  logic [PID_W-1:0]           r_pid;
  logic                       w_xfer;
  logic                       w_acc_load;
  logic                       w_acc_add;
  logic                       w_mismatch;
  logic signed [KS_MAX_ERROR_W-1:0] w_acc;

  logic                       r_corr_en;
  logic [KS_MAX_ERROR_W-1:0]  r_corr_data;
  logic [PID_W-1:0]           r_corr_pid;
  logic                       r_mismatch;

  assign ms_err_rdy = ~s_rst & (r_state != ERR_ST_EMIT);
  assign w_xfer     = ms_err_vld & ms_err_rdy;

  always_ff @(posedge clk) begin
    if (s_rst) r_state <= ERR_ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_acc_load   = 1'b0;
    w_acc_add    = 1'b0;
    w_mismatch   = 1'b0;
    unique case (r_state)
      ERR_ST_IDLE: begin
        if (w_xfer) begin
          w_acc_load   = 1'b1;
          w_next_state = ms_err_last ? ERR_ST_EMIT : ERR_ST_ACC;
        end
      end
      ERR_ST_ACC: begin
        if (w_xfer) begin
          if (ms_err_pid == r_pid) begin
            w_acc_add = 1'b1;
            if (ms_err_last) w_next_state = ERR_ST_EMIT;
          end else begin
            // Foreign-pid sample is swallowed; the open column keeps accumulating.
            w_mismatch = 1'b1;
          end
        end
      end
      ERR_ST_EMIT: w_next_state = ERR_ST_IDLE;
      default:     w_next_state = ERR_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_acc_load) r_pid <= ms_err_pid;
  end

  pep_ks_err_acc #(
    .IN_W  (ERR_IN_W),
    .ACC_W (KS_MAX_ERROR_W)
  ) u_err_acc (
    .clk      (clk),
    .s_rst    (s_rst),
    .i_load   (w_acc_load),
    .i_add    (w_acc_add),
    .i_sample (ms_err_data),
    .o_acc    (w_acc)
  );

  always_ff @(posedge clk) begin
    if (s_rst) begin
      r_corr_en  <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_corr_en  <= (r_state == ERR_ST_EMIT);
      r_mismatch <= w_mismatch;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ERR_ST_EMIT) begin
      r_corr_data <= w_acc;
      r_corr_pid  <= r_pid;
    end
  end

  assign err_pid_mismatch = r_mismatch;

  // ------------------------------------------------------- optional out stage
  if (OUT_PIPE == 1) begin : g_out_pipe
    logic                      r_wr_en_q;
    logic [MOD_KSK_W-1:0]      r_wr_data_q;
    logic [PID_W-1:0]          r_wr_pid_q;
    logic                      r_wr_parity_q;
    logic                      r_corr_en_q;
    logic [KS_MAX_ERROR_W-1:0] r_corr_data_q;
    logic [PID_W-1:0]          r_corr_pid_q;

    always_ff @(posedge clk) begin
      if (s_rst) begin
        r_wr_en_q   <= 1'b0;
        r_corr_en_q <= 1'b0;
      end else begin
        r_wr_en_q   <= r_body_en;
        r_corr_en_q <= r_corr_en;
      end
    end

    always_ff @(posedge clk) begin
      r_wr_data_q   <= r_body_data;
      r_wr_pid_q    <= r_body_pid;
      r_wr_parity_q <= r_body_parity;
      r_corr_data_q <= r_corr_data;
      r_corr_pid_q  <= r_corr_pid;
    end

    assign ks_boram_wr_en        = r_wr_en_q;
    assign ks_boram_wr_data      = r_wr_data_q;
    assign ks_boram_wr_pid       = r_wr_pid_q;
    assign ks_boram_wr_parity    = r_wr_parity_q;
    assign ks_boram_corr_wr_en   = r_corr_en_q;
    assign ks_boram_corr_wr_data = r_corr_data_q;
    assign ks_boram_corr_wr_pid  = r_corr_pid_q;
  end else begin : g_out_direct
    assign ks_boram_wr_en        = r_body_en;
    assign ks_boram_wr_data      = r_body_data;
    assign ks_boram_wr_pid       = r_body_pid;
    assign ks_boram_wr_parity    = r_body_parity;
    assign ks_boram_corr_wr_en   = r_corr_en;
    assign ks_boram_corr_wr_data = r_corr_data;
    assign ks_boram_corr_wr_pid  = r_corr_pid;
  end

endmodule

// File: tb/tb_pep_ks_boram_wr_ctrl.sv
// Bench for pep_ks_boram_wr_ctrl: directed scenarios plus random traffic, all checked
// against a column-level reference model (honours PEP_KS_BORAM_SAT_EN).
module tb_pep_ks_boram_wr_ctrl;
  import pep_ks_common_param_pkg::*;

  localparam int ERR_IN_W = 8;
  localparam int OUT_PIPE = 0;

  logic                       clk = 1'b0;
  logic                       s_rst;
  logic                       ms_err_vld;
  logic                       ms_err_rdy;
  logic signed [ERR_IN_W-1:0] ms_err_data;
  logic [PID_W-1:0]           ms_err_pid;
  logic                       ms_err_last;
  logic                       body_vld;
  logic                       body_rdy;
  logic [MOD_KSK_W-1:0]       body_data;
  logic [PID_W-1:0]           body_pid;
  logic                       body_parity;
  logic                       ks_boram_wr_en;
  logic [MOD_KSK_W-1:0]       ks_boram_wr_data;
  logic [PID_W-1:0]           ks_boram_wr_pid;
  logic                       ks_boram_wr_parity;
  logic                       ks_boram_corr_wr_en;
  logic [KS_MAX_ERROR_W-1:0]  ks_boram_corr_wr_data;
  logic [PID_W-1:0]           ks_boram_corr_wr_pid;
  logic                       err_pid_mismatch;

  pep_ks_boram_wr_ctrl #(
    .ERR_IN_W (ERR_IN_W),
    .OUT_PIPE (OUT_PIPE)
  ) dut (
    .clk                   (clk),
    .s_rst                 (s_rst),
    .ms_err_vld            (ms_err_vld),
    .ms_err_rdy            (ms_err_rdy),
    .ms_err_data           (ms_err_data),
    .ms_err_pid            (ms_err_pid),
    .ms_err_last           (ms_err_last),
    .body_vld              (body_vld),
    .body_rdy              (body_rdy),
    .body_data             (body_data),
    .body_pid              (body_pid),
    .body_parity           (body_parity),
    .ks_boram_wr_en        (ks_boram_wr_en),
    .ks_boram_wr_data      (ks_boram_wr_data),
    .ks_boram_wr_pid       (ks_boram_wr_pid),
    .ks_boram_wr_parity    (ks_boram_wr_parity),
    .ks_boram_corr_wr_en   (ks_boram_corr_wr_en),
    .ks_boram_corr_wr_data (ks_boram_corr_wr_data),
    .ks_boram_corr_wr_pid  (ks_boram_corr_wr_pid),
    .err_pid_mismatch      (err_pid_mismatch)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  // A column is "open" while samples are being summed and "closed" once its last
  // sample has been taken; a closed column blocks one cycle, then is written out.
  bit col_open   = 1'b0;
  bit col_closed = 1'b0;
  int col_pid    = 0;
  int col_sum    = 0;

  // Expected registered outputs: cur_* visible this cycle, nxt_* next cycle.
  bit                        cur_valid = 1'b0;
  bit                        exp_rdy;
  bit                        cur_body_en, nxt_body_en;
  logic [MOD_KSK_W-1:0]      cur_body_data, nxt_body_data;
  logic [PID_W-1:0]          cur_body_pid, nxt_body_pid;
  bit                        cur_body_par, nxt_body_par;
  bit                        cur_corr_en, nxt_corr_en;
  logic [KS_MAX_ERROR_W-1:0] cur_corr_data, nxt_corr_data;
  logic [PID_W-1:0]          cur_corr_pid, nxt_corr_pid;
  bit                        cur_mis, nxt_mis;

  // Observations for the directed constant checks.
  int                        corr_cnt, mis_cnt, rdy_low_cnt, both_cnt;
  logic [KS_MAX_ERROR_W-1:0] last_corr_data;
  logic [PID_W-1:0]          last_corr_pid;
  logic [MOD_KSK_W-1:0]      last_body_data;
  logic [PID_W-1:0]          last_body_pid;
  logic                      last_body_par;

  function automatic int fold(input int x);
    int lo;
    int hi;
    int m;
    int r;
    lo = -(1 <<< (KS_MAX_ERROR_W - 1));
    hi = (1 <<< (KS_MAX_ERROR_W - 1)) - 1;
    m  = 1 <<< KS_MAX_ERROR_W;
`ifdef PEP_KS_BORAM_SAT_EN
    r = (x > hi) ? hi : ((x < lo) ? lo : x);
    if (m == 0) r = x;
`else
    r = (x - lo) % m;
    if (r < 0) r += m;
    r = r + lo;
    if (hi == 0) r = x;
`endif
    return r;
  endfunction

  task automatic clear_obs();
    corr_cnt = 0; mis_cnt = 0; rdy_low_cnt = 0; both_cnt = 0;
  endtask

  // One clock cycle: evaluate the model on the driven inputs, check at negedge.
  task automatic step();
    int s;
    if (s_rst) begin
      exp_rdy     = 1'b0;
      nxt_body_en = 1'b0;
      nxt_corr_en = 1'b0;
      nxt_mis     = 1'b0;
      col_open    = 1'b0;
      col_closed  = 1'b0;
    end else begin
      exp_rdy       = !col_closed;
      nxt_body_en   = body_vld;
      nxt_body_data = body_data;
      nxt_body_pid  = body_pid;
      nxt_body_par  = body_parity;
      nxt_corr_en   = col_closed;
      nxt_corr_data = col_sum[KS_MAX_ERROR_W-1:0];
      nxt_corr_pid  = col_pid[PID_W-1:0];
      nxt_mis       = 1'b0;
      if (col_closed) begin
        col_closed = 1'b0;
      end else if (ms_err_vld) begin
        s = int'(ms_err_data);
        if (!col_open) begin
          col_pid = int'(ms_err_pid);
          col_sum = fold(s);
          if (ms_err_last) col_closed = 1'b1;
          else             col_open   = 1'b1;
        end else if (int'(ms_err_pid) != col_pid) begin
          nxt_mis = 1'b1;
        end else begin
          col_sum = fold(col_sum + s);
          if (ms_err_last) begin
            col_open   = 1'b0;
            col_closed = 1'b1;
          end
        end
      end
    end

    @(negedge clk);
    check("ms_err_rdy", 64'(ms_err_rdy), 64'(exp_rdy));
    check("body_rdy", 64'(body_rdy), 64'(!s_rst));
    if (cur_valid) begin
      check("wr_en", 64'(ks_boram_wr_en), 64'(cur_body_en));
      if (cur_body_en) begin
        check("wr_data", 64'(ks_boram_wr_data), 64'(cur_body_data));
        check("wr_pid", 64'(ks_boram_wr_pid), 64'(cur_body_pid));
        check("wr_parity", 64'(ks_boram_wr_parity), 64'(cur_body_par));
      end
      check("corr_wr_en", 64'(ks_boram_corr_wr_en), 64'(cur_corr_en));
      if (cur_corr_en) begin
        check("corr_wr_data", 64'(ks_boram_corr_wr_data), 64'(cur_corr_data));
        check("corr_wr_pid", 64'(ks_boram_corr_wr_pid), 64'(cur_corr_pid));
      end
      check("pid_mismatch", 64'(err_pid_mismatch), 64'(cur_mis));
    end
    if (ks_boram_corr_wr_en === 1'b1) begin
      corr_cnt++;
      last_corr_data = ks_boram_corr_wr_data;
      last_corr_pid  = ks_boram_corr_wr_pid;
    end
    if (ks_boram_wr_en === 1'b1) begin
      last_body_data = ks_boram_wr_data;
      last_body_pid  = ks_boram_wr_pid;
      last_body_par  = ks_boram_wr_parity;
    end
    if (err_pid_mismatch === 1'b1) mis_cnt++;
    if (!s_rst && ms_err_rdy !== 1'b1) rdy_low_cnt++;
    if (ks_boram_wr_en === 1'b1 && ks_boram_corr_wr_en === 1'b1) both_cnt++;

    @(posedge clk);
    #1;
    cur_valid     = 1'b1;
    cur_body_en   = nxt_body_en;
    cur_body_data = nxt_body_data;
    cur_body_pid  = nxt_body_pid;
    cur_body_par  = nxt_body_par;
    cur_corr_en   = nxt_corr_en;
    cur_corr_data = nxt_corr_data;
    cur_corr_pid  = nxt_corr_pid;
    cur_mis       = nxt_mis;
  endtask

  task automatic idle(input int n);
    ms_err_vld = 1'b0;
    body_vld   = 1'b0;
    repeat (n) step();
  endtask

  task automatic err(input int d, input int p, input bit l);
    ms_err_vld  = 1'b1;
    ms_err_data = ERR_IN_W'(d);
    ms_err_pid  = PID_W'(p);
    ms_err_last = l;
    step();
    ms_err_vld  = 1'b0;
  endtask

  initial begin
    s_rst = 1'b1;
    ms_err_vld = 1'b0; ms_err_data = '0; ms_err_pid = '0; ms_err_last = 1'b0;
    body_vld = 1'b0; body_data = '0; body_pid = '0; body_parity = 1'b0;
    clear_obs();
    @(posedge clk);
    #1;
    idle(3);
    s_rst = 1'b0;
    idle(2);

    // Body pass-through latency and payload.
    body_vld = 1'b1; body_data = 32'h1234; body_pid = 4'd5; body_parity = 1'b1;
    step();
    body_vld = 1'b0;
    idle(1);
    check("body_0x1234_data", 64'(last_body_data), 64'h1234);
    check("body_0x1234_pid", 64'(last_body_pid), 64'd5);
    check("body_0x1234_par", 64'(last_body_par), 64'd1);

    // Three-sample column: 3 - 1 + 7.
    clear_obs();
    err(3, 9, 0); err(-1, 9, 0); err(7, 9, 1);
    idle(4);
    check("col3_count", 64'(corr_cnt), 64'd1);
    check("col3_sum", 64'(last_corr_data), 64'd9);
    check("col3_pid", 64'(last_corr_pid), 64'd9);
    check("col3_rdy_low", 64'(rdy_low_cnt), 64'd1);

    // Foreign pid mid-column is dropped.
    clear_obs();
    err(1, 2, 0); err(2, 2, 0); err(5, 4, 0); err(3, 2, 1);
    idle(4);
    check("mis_pulses", 64'(mis_cnt), 64'd1);
    check("mis_corr_count", 64'(corr_cnt), 64'd1);
    check("mis_sum", 64'(last_corr_data), 64'd6);
    check("mis_pid", 64'(last_corr_pid), 64'd2);

    // Ten samples of +127 overflow an 8-bit accumulator.
    clear_obs();
    for (int i = 0; i < 10; i++) err(127, 1, i == 9);
    idle(4);
    check("ovf_count", 64'(corr_cnt), 64'd1);
`ifdef PEP_KS_BORAM_SAT_EN
    check("ovf_sum", 64'(last_corr_data), 64'h7f);
`else
    check("ovf_sum", 64'(last_corr_data), 64'hf6);
`endif

    // Reset mid-column drops the partial sum.
    clear_obs();
    err(4, 3, 0); err(4, 3, 0);
    s_rst = 1'b1;
    idle(1);
    s_rst = 1'b0;
    idle(3);
    check("rst_no_corr", 64'(corr_cnt), 64'd0);
    err(5, 3, 1);
    idle(4);
    check("rst_fresh_sum", 64'(last_corr_data), 64'd5);

    // Body and correction write for pid 7 land in the same cycle.
    clear_obs();
    err(11, 7, 1);
    body_vld = 1'b1; body_data = 32'hcafe_0007; body_pid = 4'd7; body_parity = 1'b0;
    step();
    body_vld = 1'b0;
    idle(3);
    check("same_cycle", 64'(both_cnt), 64'd1);
    check("same_corr_data", 64'(last_corr_data), 64'd11);
    check("same_corr_pid", 64'(last_corr_pid), 64'd7);
    check("same_body_data", 64'(last_body_data), 64'hcafe_0007);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s_rst       = ($urandom_range(0, 63) == 0);
      ms_err_vld  = ($urandom_range(0, 2) != 0);
      ms_err_data = ERR_IN_W'($urandom);
      ms_err_pid  = PID_W'($urandom_range(0, 3));
      ms_err_last = ($urandom_range(0, 3) == 0);
      body_vld    = ($urandom_range(0, 1) != 0);
      body_data   = MOD_KSK_W'($urandom);
      body_pid    = PID_W'($urandom);
      body_parity = 1'($urandom);
      step();
    end
    s_rst = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
